dct_frame_arbiter: RTL and testbench

- Shares one 4x4 DCT core between two requesters (ch0, ch1), one frame at a time.
- A frame is 16 signed 8-bit samples in. The result is 16 signed 10-bit coefficients out.
- The block grants a requester, forwards its samples into the core as one contiguous burst, then waits for the core's result burst and routes it back to the owning channel.
- A watchdog aborts frames the core never answers. The block sits between the pixel/block sources and the DCT core.

---
 rtl/dct_frame_arbiter_if.sv | 36 +++
 rtl/dct_frame_arbiter.sv | 146 ++++++++++++++
 tb/tb_dct_frame_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dct_frame_arbiter_if.sv
// Requester, core and result signals of the DCT frame arbiter.
// master = arbiter side, slave = sources/core/sinks side.
interface dct_frame_arbiter_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 10
);
    logic                    req0;
    logic                    req1;
    logic signed [IN_W-1:0]  data0;
    logic signed [IN_W-1:0]  data1;
    logic                    gnt0;
    logic                    gnt1;
    logic                    core_in_valid;
    logic signed [IN_W-1:0]  core_in_data;
    logic                    core_out_valid;
    logic signed [OUT_W-1:0] core_out_data;
    logic                    out0_valid;
    logic                    out1_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    done0;
    logic                    done1;
    logic                    err;
    logic                    busy;

    modport master (
        input  req0, req1, data0, data1, core_out_valid, core_out_data,
        output gnt0, gnt1, core_in_valid, core_in_data,
               out0_valid, out1_valid, out_data, done0, done1, err, busy
    );

    modport slave (
        output req0, req1, data0, data1, core_out_valid, core_out_data,
        input  gnt0, gnt1, core_in_valid, core_in_data,
               out0_valid, out1_valid, out_data, done0, done1, err, busy
    );
endinterface

// File: rtl/dct_frame_arbiter.sv
// Two-channel frame arbiter in front of a shared 4x4 DCT core: grant, load 16
// samples, wait for the core (with watchdog), drain 16 coefficients to the owner.
module dct_frame_arbiter #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 10,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    dct_frame_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [7:0] LP_WAIT_MAX = 8'(TIMEOUT - 1);

    logic [1:0]              r_state;
    logic                    r_owner;
    logic                    r_ptr;
    logic [3:0]              r_smp_cnt;
    logic [3:0]              r_beat_cnt;
    logic [7:0]              r_wait_cnt;
    logic                    r_gnt0;
    logic                    r_gnt1;
    logic                    r_cin_valid;
    logic signed [IN_W-1:0]  r_cin_data;
    logic                    r_out0_valid;
    logic                    r_out1_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_done0;
    logic                    r_done1;
    logic                    r_err;

    logic                    w_any_req;
    logic                    w_win;
    logic                    w_gnt_any;
    logic signed [IN_W-1:0]  w_owner_data;

    // Contention goes to the pointer; a lone requester wins regardless of it.
    assign w_any_req    = bus.req0 | bus.req1;
    assign w_win        = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
    assign w_gnt_any    = r_gnt0 | r_gnt1;
    assign w_owner_data = r_owner ? bus.data1 : bus.data0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_ptr        <= 1'b0;
            r_smp_cnt    <= '0;
            r_beat_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_cin_valid  <= 1'b0;
            r_cin_data   <= '0;
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
            r_out_data   <= '0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
            r_out_data   <= '0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err        <= 1'b0;
            r_cin_valid  <= w_gnt_any;
            r_cin_data   <= w_gnt_any ? w_owner_data : '0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_win;
                        r_gnt0    <= ~w_win;
                        r_gnt1    <= w_win;
                        r_smp_cnt <= '0;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_smp_cnt == 4'd15) begin
                        r_gnt0     <= 1'b0;
                        r_gnt1     <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= S_WAIT;
                    end else begin
                        r_smp_cnt <= r_smp_cnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    // The first result beat is accepted here as beat 0.
                    if (bus.core_out_valid) begin
                        r_out_data   <= bus.core_out_data;
                        r_out0_valid <= ~r_owner;
                        r_out1_valid <= r_owner;
                        r_beat_cnt   <= 4'd1;
                        r_state      <= S_DRAIN;
                    end else if (r_wait_cnt == LP_WAIT_MAX) begin
                        r_err   <= 1'b1;
                        r_ptr   <= ~r_owner;
                        r_state <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    if (bus.core_out_valid) begin
                        r_out_data   <= bus.core_out_data;
                        r_out0_valid <= ~r_owner;
                        r_out1_valid <= r_owner;
                        if (r_beat_cnt == 4'd15) begin
                            r_done0 <= ~r_owner;
                            r_done1 <= r_owner;
                            r_ptr   <= ~r_owner;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 4'd1;
                        end
                    end else begin
                        // Short burst: abandon the frame.
                        r_err   <= 1'b1;
                        r_ptr   <= ~r_owner;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.gnt0          = r_gnt0;
    assign bus.gnt1          = r_gnt1;
    assign bus.core_in_valid = r_cin_valid;
    assign bus.core_in_data  = r_cin_data;
    assign bus.out0_valid    = r_out0_valid;
    assign bus.out1_valid    = r_out1_valid;
    assign bus.out_data      = r_out_data;
    assign bus.done0         = r_done0;
    assign bus.done1         = r_done1;
    assign bus.err           = r_err;
    assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_dct_frame_arbiter.sv
// Frame-level bench for dct_frame_arbiter: behavioural core model plus a
// transaction-level expectation of winner, bursts, result routing and errors.
module tb_dct_frame_arbiter;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 10;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_frame_arbiter_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    dct_frame_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // frame stimulus and core behaviour
    logic signed [IN_W-1:0]  smp [16];
    logic signed [OUT_W-1:0] rsp [16];
    int nbeats, dly, resp_start, cb_idx;
    int cb_time [16];
    int late_cyc, late_ch;
    int exp_ptr;

    // observation logs
    int cyc;
    int g_cnt [2];
    int g_first, g_last;
    int cin_cnt, cin_first, cin_bad;
    int o_cnt [2];
    int o_bad, o_last, zero_bad;
    int done_cnt [2];
    int done_cyc, err_cnt, err_cyc;

    task automatic clear_logs();
        g_cnt[0] = 0; g_cnt[1] = 0; g_first = -1; g_last = -1;
        cin_cnt = 0; cin_first = -1; cin_bad = 0;
        o_cnt[0] = 0; o_cnt[1] = 0; o_bad = 0; o_last = -1; zero_bad = 0;
        done_cnt[0] = 0; done_cnt[1] = 0; done_cyc = -1;
        err_cnt = 0; err_cyc = -1;
        resp_start = NEVER; cb_idx = 0; late_cyc = -1;
        for (int i = 0; i < 16; i++) cb_time[i] = -10;
    endtask

    // One clock: observe outputs for this cycle, then drive inputs for it.
    task automatic tick();
        int k;
        @(negedge clk);
        cyc++;
        if (bus.gnt0) g_cnt[0]++;
        if (bus.gnt1) g_cnt[1]++;
        if (bus.gnt0 || bus.gnt1) begin
            if (g_first < 0) g_first = cyc;
            g_last = cyc;
        end
        if (bus.core_in_valid) begin
            if (cin_cnt == 0) cin_first = cyc;
            if (cin_cnt < 16) begin
                if (bus.core_in_data != smp[cin_cnt]) cin_bad++;
            end
            cin_cnt++;
            if (cin_cnt == 16) resp_start = cyc + dly;
        end
        if (bus.out0_valid) o_cnt[0]++;
        if (bus.out1_valid) o_cnt[1]++;
        if (bus.out0_valid || bus.out1_valid) begin
            k = o_cnt[0] + o_cnt[1] - 1;
            if (bus.out0_valid && bus.out1_valid) o_bad++;
            else if (k > 15) o_bad++;
            else if (bus.out_data != rsp[k] || cyc != cb_time[k] + 1) o_bad++;
            o_last = cyc;
        end else if (bus.out_data != '0) begin
            zero_bad++;
        end
        if (bus.done0) begin done_cnt[0]++; done_cyc = cyc; end
        if (bus.done1) begin done_cnt[1]++; done_cyc = cyc; end
        if (bus.err) begin err_cnt++; err_cyc = cyc; end

        if (bus.gnt0) bus.data0 = smp[(g_cnt[0] - 1) & 15];
        else          bus.data0 = IN_W'($urandom);
        if (bus.gnt1) bus.data1 = smp[(g_cnt[1] - 1) & 15];
        else          bus.data1 = IN_W'($urandom);
        if (cyc >= resp_start && cb_idx < nbeats) begin
            bus.core_out_valid = 1'b1;
            bus.core_out_data  = rsp[cb_idx];
            cb_time[cb_idx]    = cyc;
            cb_idx++;
        end else begin
            bus.core_out_valid = 1'b0;
            bus.core_out_data  = OUT_W'($urandom);
        end
        if (cyc == late_cyc) begin
            if (late_ch == 0) bus.req0 = 1'b1;
            else              bus.req1 = 1'b1;
        end
    endtask

    task automatic do_reset();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        nbeats = 0; clear_logs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        exp_ptr = 0;
        tick();
    endtask

    // nb: result beats the core returns (16 full, 1..15 short, 0 never)
    task automatic run_frame(input bit r0, input bit r1, input int nb, input int d,
                             input bit ramp, input int rst_at, input bit late);
        int win, start, t;
        for (int i = 0; i < 16; i++) begin
            smp[i] = ramp ? IN_W'(i) : IN_W'($urandom);
            rsp[i] = ramp ? OUT_W'(100 + i) : OUT_W'($urandom);
        end
        clear_logs();
        nbeats = nb;
        dly    = d;
        win    = (r0 && r1) ? exp_ptr : (r1 ? 1 : 0);
        bus.req0 = r0;
        bus.req1 = r1;
        start = cyc;
        if (late && !(r0 && r1)) begin
            late_ch  = 1 - win;
            late_cyc = start + int'($urandom_range(18, 2));
        end
        t = 0;
        do begin
            tick();
            t++;
            if (rst_at > 0 && g_cnt[win] == rst_at) begin
                rst = 1'b1;
                tick();
                chk("rst_mid_gnt0", bus.gnt0, 0);
                chk("rst_mid_cin_valid", bus.core_in_valid, 0);
                chk("rst_mid_busy", bus.busy, 0);
                rst = 1'b0;
                bus.req0 = 1'b0; bus.req1 = 1'b0;
                nbeats = 0; resp_start = NEVER;
                exp_ptr = 0;
                tick();
                return;
            end
        end while (t < 400 && !(t > 1 && !bus.busy));

        chk("frame_ends", int'(t < 400), 1);
        chk("gnt_win_cnt", g_cnt[win], 16);
        chk("gnt_lose_cnt", g_cnt[1 - win], 0);
        chk("gnt_start", g_first, start + 1);
        chk("gnt_contig", g_last - g_first + 1, 16);
        chk("cin_cnt", cin_cnt, 16);
        chk("cin_skew", cin_first, g_first + 1);
        chk("cin_data_bad", cin_bad, 0);
        chk("out_win_cnt", o_cnt[win], nb);
        chk("out_lose_cnt", o_cnt[1 - win], 0);
        chk("out_beat_bad", o_bad, 0);
        chk("out_idle_nonzero", zero_bad, 0);
        chk("done_win", done_cnt[win], int'(nb == 16));
        chk("done_lose", done_cnt[1 - win], 0);
        if (nb == 16) chk("done_with_last", done_cyc, o_last);
        chk("err_cnt", err_cnt, int'(nb < 16));
        if (nb == 0)      chk("err_timeout_cyc", err_cyc, g_last + 1 + TIMEOUT);
        else if (nb < 16) chk("err_short_cyc", err_cyc, cb_time[nb - 1] + 2);
        exp_ptr = 1 - win;
    endtask

    initial begin
        cyc = 0; exp_ptr = 0; nbeats = 0; dly = 1; late_ch = 0;
        for (int i = 0; i < 16; i++) begin smp[i] = '0; rsp[i] = '0; end
        clear_logs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.data0 = '0; bus.data1 = '0;
        bus.core_out_valid = 1'b0; bus.core_out_data = '0;

        rst = 1'b1;
        tick(); tick();
        chk("rst_gnt", {bus.gnt1, bus.gnt0}, 0);
        chk("rst_cin", bus.core_in_valid, 0);
        chk("rst_out", {bus.out1_valid, bus.out0_valid, bus.done1, bus.done0, bus.err}, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();

        // ch0 alone, ramp in, 100..115 back after 20 cycles
        run_frame(1'b1, 1'b0, 16, 20, 1'b1, 0, 1'b0);

        // both requesting from reset: 0, 1, 0
        do_reset();
        for (int f = 0; f < 3; f++) run_frame(1'b1, 1'b1, 16, int'($urandom_range(30, 1)), 1'b0, 0, 1'b0);

        // lone ch1 served back-to-back
        for (int f = 0; f < 3; f++) run_frame(1'b0, 1'b1, 16, int'($urandom_range(30, 1)), 1'b0, 0, 1'b0);

        // core never answers, then a short 10-beat burst
        run_frame(1'b1, 1'b0, 0, 1, 1'b0, 0, 1'b0);
        run_frame(1'b1, 1'b0, 10, 5, 1'b0, 0, 1'b0);

        // reset in the 7th LOAD cycle, then a clean frame under contention
        run_frame(1'b1, 1'b0, 16, 10, 1'b0, 7, 1'b0);
        run_frame(1'b1, 1'b1, 16, 12, 1'b1, 0, 1'b0);

        for (int f = 0; f < 12; f++) begin
            int r, nb;
            bit a, b;
            r = int'($urandom_range(2, 0));
            a = (r != 1);
            b = (r != 0);
            r = int'($urandom_range(9, 0));
            nb = (r < 7) ? 16 : ((r < 9) ? int'($urandom_range(15, 1)) : 0);
            run_frame(a, b, nb, int'($urandom_range(40, 1)), 1'b0, 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
